// File: rtl/ball_renderer.sv
// ball_renderer: draws a bouncing square ball over a solid background.
// Sits directly behind the sync generator; the ball position advances once
// per frame on the vsync rising edge, and every video output is registered
// so colour and sync leave the block aligned.
module ball_renderer #(
    parameter int H_DISPLAY = 256,
    parameter int V_DISPLAY = 240,
    parameter int BALL_SIZE = 4,
    parameter int INIT_X    = 128,
    parameter int INIT_Y    = 120,
    parameter int SPEED     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       display_on,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       pause,
    output logic [2:0] rgb,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       display_on_o,
    output logic [8:0] ball_x,
    output logic [8:0] ball_y,
    output logic [7:0] bounces
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_X = 2'd1,
        MOVE_Y = 2'd2
    } state_t;

    // All position math is carried in 10 bits so ball + SPEED never wraps.
    localparam logic [9:0] X_MAX  = 10'(H_DISPLAY - BALL_SIZE);
    localparam logic [9:0] Y_MAX  = 10'(V_DISPLAY - BALL_SIZE);
    localparam logic [9:0] SPD    = 10'(SPEED);
    localparam logic [9:0] BSZ    = 10'(BALL_SIZE);
    localparam logic [8:0] X_INIT = 9'(INIT_X);
    localparam logic [8:0] Y_INIT = 9'(INIT_Y);

    state_t     state;
    logic       vsync_prev;
    logic       frame_tick;
    logic       dir_x;
    logic       dir_y;
    logic [9:0] bx_wide;
    logic [9:0] by_wide;
    logic [9:0] nx_inc;
    logic [9:0] ny_inc;
    logic [9:0] nx_dec;
    logic [9:0] ny_dec;
    logic       hit;

    // Frame edge detect, candidate next positions and the ball hit test.
    always_comb begin
        frame_tick = vsync & ~vsync_prev;
        bx_wide    = {1'b0, ball_x};
        by_wide    = {1'b0, ball_y};
        nx_inc     = bx_wide + SPD;
        ny_inc     = by_wide + SPD;
        nx_dec     = bx_wide - SPD;
        ny_dec     = by_wide - SPD;
        hit        = display_on
                     && ({1'b0, hpos} >= bx_wide) && ({1'b0, hpos} < bx_wide + BSZ)
                     && ({1'b0, vpos} >= by_wide) && ({1'b0, vpos} < by_wide + BSZ);
    end

    // Motion FSM: one X step then one Y step per accepted frame tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vsync_prev <= 1'b0;
            ball_x     <= X_INIT;
            ball_y     <= Y_INIT;
            dir_x      <= 1'b0;
            dir_y      <= 1'b0;
            bounces    <= 8'd0;
        end else begin
            vsync_prev <= vsync;
            case (state)
                IDLE: begin
                    // A tick seen while paused is simply dropped.
                    if (frame_tick && !pause) begin
                        state <= MOVE_X;
                    end else begin
                        state <= IDLE;
                    end
                end
                MOVE_X: begin
                    state <= MOVE_Y;
                    if (!dir_x) begin
                        if (nx_inc > X_MAX) begin
                            ball_x  <= X_MAX[8:0];
                            dir_x   <= 1'b1;
                            bounces <= bounces + 8'd1;
                        end else begin
                            ball_x  <= nx_inc[8:0];
                        end
                    end else begin
                        if (bx_wide < SPD) begin
                            ball_x  <= 9'd0;
                            dir_x   <= 1'b0;
                            bounces <= bounces + 8'd1;
                        end else begin
                            ball_x  <= nx_dec[8:0];
                        end
                    end
                end
                MOVE_Y: begin
                    state <= IDLE;
                    if (!dir_y) begin
                        if (ny_inc > Y_MAX) begin
                            ball_y  <= Y_MAX[8:0];
                            dir_y   <= 1'b1;
                            bounces <= bounces + 8'd1;
                        end else begin
                            ball_y  <= ny_inc[8:0];
                        end
                    end else begin
                        if (by_wide < SPD) begin
                            ball_y  <= 9'd0;
                            dir_y   <= 1'b0;
                            bounces <= bounces + 8'd1;
                        end else begin
                            ball_y  <= ny_dec[8:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pixel output stage: colour and sync delayed together by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb          <= 3'b000;
            hsync_o      <= 1'b0;
            vsync_o      <= 1'b0;
            display_on_o <= 1'b0;
        end else begin
            hsync_o      <= hsync;
            vsync_o      <= vsync;
            display_on_o <= display_on;
            if (hit) begin
                rgb <= 3'b111;
            end else if (display_on) begin
                rgb <= 3'b001;
            end else begin
                rgb <= 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_ball_renderer.sv
// Testbench for ball_renderer: directed checks from reset through wall
// bounces, pause and mid-update reset, then randomized frames and pixel
// probes compared against a velocity-based ball model.
module tb_ball_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       pause;
    logic [2:0] rgb;
    logic       hsync_o;
    logic       vsync_o;
    logic       display_on_o;
    logic [8:0] ball_x;
    logic [8:0] ball_y;
    logic [7:0] bounces;

    int checks = 0;
    int errors = 0;

    // Reference model: position and signed velocity per axis.
    int mx, my, vx, vy, mb;

    ball_renderer dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .hpos(hpos), .vpos(vpos), .pause(pause),
        .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .display_on_o(display_on_o), .ball_x(ball_x), .ball_y(ball_y),
        .bounces(bounces)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        mx = 128; my = 120; vx = 2; vy = 2; mb = 0;
    endtask

    // Move one axis by its velocity and reflect off [0, lim].
    task automatic model_axis(inout int p, inout int v, input int lim);
        p = p + v;
        if (p > lim) begin
            p = lim; v = -v; mb = (mb + 1) % 256;
        end else if (p < 0) begin
            p = 0; v = -v; mb = (mb + 1) % 256;
        end
    endtask

    task automatic do_frame(input logic p);
        pause = p;
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
        if (!p) begin
            model_axis(mx, vx, 252);
            model_axis(my, vy, 236);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_x"}, int'(ball_x), mx);
        check({tag, "_y"}, int'(ball_y), my);
        check({tag, "_bounces"}, int'(bounces), mb);
    endtask

    function automatic int exp_rgb(input logic de, input int hp, input int vp);
        if (de && hp >= mx && hp < mx + 4 && vp >= my && vp < my + 4) return 7;
        if (de) return 1;
        return 0;
    endfunction

    initial begin
        reset = 1'b1; hsync = 1'b0; vsync = 1'b0; display_on = 1'b0;
        hpos = 9'd0; vpos = 9'd0; pause = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset_rgb", int'(rgb), 0);
        check_model("reset");

        // vsync rise while held in reset must not move the ball
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        tick();
        check_model("reset_hold");
        reset = 1'b0;
        tick();

        // Pixel path
        display_on = 1'b1; hpos = 9'd128; vpos = 9'd120; tick();
        check("pix_hit", int'(rgb), 7);
        hpos = 9'd132; vpos = 9'd120; tick();
        check("pix_right_edge", int'(rgb), 1);
        hpos = 9'd128; vpos = 9'd124; tick();
        check("pix_bottom_edge", int'(rgb), 1);
        hpos = 9'd131; vpos = 9'd123; tick();
        check("pix_corner_in", int'(rgb), 7);
        display_on = 1'b0; hpos = 9'd130; vpos = 9'd121;
        check("de_o_before", int'(display_on_o), 1);
        tick();
        check("pix_blank", int'(rgb), 0);
        check("de_o_after", int'(display_on_o), 0);

        // Sync delay, paused so the vsync rise is discarded
        pause = 1'b1; hsync = 1'b1;
        check("hsync_o_before", int'(hsync_o), 0);
        tick();
        check("hsync_o_after", int'(hsync_o), 1);
        hsync = 1'b0; vsync = 1'b1;
        check("vsync_o_before", int'(vsync_o), 0);
        tick();
        check("vsync_o_after", int'(vsync_o), 1);
        check("hsync_o_fall", int'(hsync_o), 0);
        vsync = 1'b0; tick();
        pause = 1'b0; tick();
        check("vsync_o_fall", int'(vsync_o), 0);
        repeat (3) tick();
        check_model("paused_sync");

        // One long vsync pulse gives exactly one update
        vsync = 1'b1;
        repeat (2) tick();
        check("long_x_at2", int'(ball_x), 130);
        check("long_y_at2", int'(ball_y), 120);
        tick();
        check("long_y_at3", int'(ball_y), 122);
        repeat (500) tick();
        check("long_x_hold", int'(ball_x), 130);
        check("long_y_hold", int'(ball_y), 122);
        vsync = 1'b0; repeat (2) tick();

        // Wall bounces from a fresh reset
        reset = 1'b1; tick(); reset = 1'b0; tick();
        model_reset();
        repeat (59) do_frame(1'b0);
        check("f59_y", int'(ball_y), 236);
        check("f59_x", int'(ball_x), 246);
        check("f59_bounces", int'(bounces), 1);
        check_model("f59_model");
        repeat (4) do_frame(1'b0);
        check("f63_x", int'(ball_x), 252);
        check("f63_y", int'(ball_y), 228);
        check("f63_bounces", int'(bounces), 2);

        // Pause over 10 frames, then release
        repeat (10) do_frame(1'b1);
        check_model("paused10");
        check("paused10_x", int'(ball_x), 252);
        do_frame(1'b0);
        check("unpause_x", int'(ball_x), 250);
        check("unpause_y", int'(ball_y), 226);
        check_model("unpause");

        // Reset during MOVE_X
        vsync = 1'b1; tick();
        reset = 1'b1; #1;
        model_reset();
        check_model("mid_reset");
        check("mid_reset_rgb", int'(rgb), 0);
        vsync = 1'b0; tick();
        reset = 1'b0; tick();
        check_model("mid_reset_idle");
        do_frame(1'b0);
        check("post_reset_x", int'(ball_x), 130);
        check("post_reset_y", int'(ball_y), 122);

        // Randomized frames with pixel probes around the ball
        for (int f = 0; f < 150; f++) begin
            do_frame(($urandom % 4) == 0);
            check_model("rand_frame");
            for (int k = 0; k < 3; k++) begin
                int hp, vp;
                logic de;
                de = ($urandom % 5) != 0;
                hp = mx - 1 + int'($urandom_range(0, 6));
                vp = my - 1 + int'($urandom_range(0, 6));
                if (hp < 0) hp = 0;
                if (vp < 0) vp = 0;
                display_on = de; hpos = 9'(hp); vpos = 9'(vp);
                tick();
                check("rand_rgb", int'(rgb), exp_rgb(de, hp, vp));
            end
            display_on = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
